exe_stage_mc: RTL
=================

Name: exe_stage_mc

Overview:
Parametrised execute stage for the RISC-V pipeline, sitting between ID/EX and EX/MEM.
- Two-source operand forwarding, one per operand: MEM-stage result or WB-stage result.
- Registered ALU result.
- Iterative multi-cycle multiplier that stalls upstream through a busy handshake.
- Generalises the single-cycle execute stage in datapath width, PC width, forwarding depth and op set.

Parameters:
XLEN, 32, datapath width (power of two, 8..64)
PCW, 8, PC+4 width, zero-extended to XLEN
RW, 5, register-address width
SHW, $clog2(XLEN), shift-amount bits taken from operand B

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
nos  in  1  flush: bubble the output and abort any multiply
in_valid  in  1  ID/EX holds a valid instruction
ctl_alusrc_in  in  1  operand B = imm when 1
ctl_memtoreg_in  in  1  passed to EX/MEM
ctl_regwrite_in  in  1  passed to EX/MEM
ctl_link_in  in  1  jal/jalr: result = PC+4
alu_ctl_in  in  4  operation code
fwd_a_in  in  2  operand A source: 00 rs1, 01 MEM, 10 WB, 11 rs1
fwd_b_in  in  2  operand B / store data source, same encoding
rd_in  in  RW  destination register
rs1_data_in  in  XLEN  register-file read 1
rs2_data_in  in  XLEN  register-file read 2
imm_in  in  XLEN  immediate
mem_fwd_in  in  XLEN  EX/MEM ALU result
wb_fwd_in  in  XLEN  MEM/WB write data
pc4_in  in  PCW  PC+4
busy_out  out  1  stall: upstream must hold ID/EX
out_valid  out  1  EX/MEM slot holds a valid result
ctl_memtoreg_out  out  1  registered
ctl_regwrite_out  out  1  registered
rd_out  out  RW  registered
alu_result_out  out  XLEN  registered result
mem_wdata_out  out  XLEN  registered store data (forwarded B before the imm mux)

Behaviour:
Op codes:
- AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111 (signed, result 0/1), SLL=1001, SRL=1010, SRA=1011, MUL=1101 (low XLEN bits of the product).
- Any other code: result 0, never X.
- Shifts use B[SHW-1:0] only.

Reset:
- All outputs 0; FSM in IDLE; counter 0.

Single-cycle ops:
- Operands are selected combinationally.
- All outputs register on the next rising edge (latency 1).
- out_valid = in_valid.
- ctl_link_in overrides the result with zero-extended pc4_in.

FSM states and transitions:
- IDLE:
  - in_valid & alu_ctl==MUL & !nos: busy_out=1 combinationally.
  - Forwarded A/B are latched into mcand/mplier, acc=0, cnt=XLEN-1 → MUL.
  - The output slot gets a bubble: out_valid=0, regwrite=0, memtoreg=0.
- MUL:
  - Each cycle: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt--.
  - busy_out=1 while cnt!=0; output slot keeps bubbling.
  - When cnt==0: busy_out=0. acc plus the final partial product is registered to alu_result_out with out_valid=1; rd and ctl fields come from the still-held ID/EX inputs. → IDLE.
  - The held MUL must not re-issue in this cycle.
- Latency: for XLEN=32, busy_out is high for 32 cycles and the result is visible after the 33rd edge from issue.
- Latched operands are immune to forwarding changes during MUL.

Flush (nos=1):
- Next edge: out_valid, ctl_regwrite_out, ctl_memtoreg_out = 0.
- FSM → IDLE; busy_out drops combinationally in the same cycle.
- rd_out, alu_result_out and mem_wdata_out may still update; their values are don't-care.
- nos together with a MUL issue: no issue.

Other rules:
- in_valid=0: bubble is registered, FSM unaffected.
- Reset asserted mid-multiply: immediate return to IDLE, all outputs 0.
- x0 destinations are not checked; decode guarantees regwrite=0 for them.

Decomposition:
- Shared package exe_pkg: ALU op-code localparams, forwarding-select encodings (FWD_RF, FWD_MEM, FWD_WB), FSM state enum.
- Sub-module mul_iter: the shift-add multiplier FSM.
  - Ports: clk, rst, start, abort, a, b, busy, last, product.
  - Parametrised by XLEN.
- The combinational ALU stays inline in exe_stage_mc.

Test Plan:
- ADD, rs1=5, imm=7, alusrc=1, in_valid=1 → next edge: alu_result_out=12, out_valid=1, rd_out=rd_in.
- SUB with fwd_a=01, mem_fwd=100, rs2=30 → result 70. Repeat with fwd_b=10, wb_fwd=3 → result 97 and mem_wdata_out=3.
- SRA, A=0x8000_0000, B=0x21 (XLEN=32, shamt=1) → 0xC000_0000. SLT with -1 vs 1 → 1.
- MUL, A=0xFFFF_FFFF, B=3, held for the busy period:
  - busy_out high for exactly 32 cycles; out_valid=0 throughout.
  - Then alu_result_out=0xFFFF_FFFD, out_valid=1 for one cycle.
  - Then the next instruction executes.
- MUL issued, nos pulsed on iteration 10 → busy_out low that cycle, no valid output. A following ADD 1+1 → 2 with latency 1.
- rst asserted asynchronously mid-MUL → all outputs 0 immediately. After release, ctl_link_in=1, pc4_in=0x24 → alu_result_out=0x24.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage: ALU op codes, forwarding selects
// and the multiplier sequencer states.
package exe_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRL = 4'b1010;
  localparam logic [3:0] ALU_SRA = 4'b1011;
  localparam logic [3:0] ALU_MUL = 4'b1101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier returning the low XLEN bits of a*b.
// busy covers the issue cycle and every iteration except the last one.
module mul_iter
  import exe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            last,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  mul_state_e      r_state;
  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [CW-1:0]   r_cnt;

  logic            w_idle;
  logic            w_cnt_zero;
  logic [XLEN-1:0] w_pp;
  logic [XLEN-1:0] w_acc_next;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_cnt_zero = (r_cnt == {CW{1'b0}});
  assign w_pp       = r_mplier[0] ? r_mcand : {XLEN{1'b0}};
  assign w_acc_next = r_acc + w_pp;

  // Final cycle folds the last partial product in combinationally.
  assign busy    = rst & ~abort & ((w_idle & start) | (~w_idle & ~w_cnt_zero));
  assign last    = rst & ~abort & ~w_idle & w_cnt_zero;
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_mcand  <= {XLEN{1'b0}};
      r_mplier <= {XLEN{1'b0}};
      r_acc    <= {XLEN{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else if (abort) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= {XLEN{1'b0}};
            r_cnt    <= CW'(XLEN - 1);
            r_state  <= ST_MUL;
          end
        end
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= {r_mcand[XLEN-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
          if (w_cnt_zero) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// RISC-V execute stage: operand forwarding, inline ALU, registered EX/MEM
// outputs and a stalling multi-cycle multiplier. Requires PCW < XLEN.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PCW  = 8,
  parameter int RW   = 5,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nos,
  input  logic            in_valid,
  input  logic            ctl_alusrc_in,
  input  logic            ctl_memtoreg_in,
  input  logic            ctl_regwrite_in,
  input  logic            ctl_link_in,
  input  logic [3:0]      alu_ctl_in,
  input  logic [1:0]      fwd_a_in,
  input  logic [1:0]      fwd_b_in,
  input  logic [RW-1:0]   rd_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] mem_fwd_in,
  input  logic [XLEN-1:0] wb_fwd_in,
  input  logic [PCW-1:0]  pc4_in,
  output logic            busy_out,
  output logic            out_valid,
  output logic            ctl_memtoreg_out,
  output logic            ctl_regwrite_out,
  output logic [RW-1:0]   rd_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] mem_wdata_out
);

  logic [XLEN-1:0] w_op_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_op_b;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_alu;
  logic [XLEN-1:0] w_result;
  logic [XLEN-1:0] w_product;
  logic            w_is_mul;
  logic            w_mul_busy;
  logic            w_mul_last;

  always_comb begin
    case (fwd_a_in)
      FWD_MEM: w_op_a = mem_fwd_in;
      FWD_WB:  w_op_a = wb_fwd_in;
      default: w_op_a = rs1_data_in;
    endcase
    case (fwd_b_in)
      FWD_MEM: w_fwd_b = mem_fwd_in;
      FWD_WB:  w_fwd_b = wb_fwd_in;
      default: w_fwd_b = rs2_data_in;
    endcase
  end

  assign w_op_b  = ctl_alusrc_in ? imm_in : w_fwd_b;
  assign w_shamt = w_op_b[SHW-1:0];

  // MUL and unknown codes yield zero here; the product comes from mul_iter.
  always_comb begin
    w_alu = {XLEN{1'b0}};
    case (alu_ctl_in)
      ALU_AND: w_alu = w_op_a & w_op_b;
      ALU_OR:  w_alu = w_op_a | w_op_b;
      ALU_ADD: w_alu = w_op_a + w_op_b;
      ALU_SUB: w_alu = w_op_a - w_op_b;
      ALU_SLT: w_alu = {{(XLEN-1){1'b0}}, ($signed(w_op_a) < $signed(w_op_b))};
      ALU_SLL: w_alu = w_op_a << w_shamt;
      ALU_SRL: w_alu = w_op_a >> w_shamt;
      ALU_SRA: w_alu = $unsigned($signed(w_op_a) >>> w_shamt);
      default: w_alu = {XLEN{1'b0}};
    endcase
  end

  assign w_result = ctl_link_in ? {{(XLEN-PCW){1'b0}}, pc4_in} : w_alu;
  assign w_is_mul = in_valid & (alu_ctl_in == ALU_MUL);

  mul_iter #(
    .XLEN(XLEN)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (w_is_mul),
    .abort  (nos),
    .a      (w_op_a),
    .b      (w_op_b),
    .busy   (w_mul_busy),
    .last   (w_mul_last),
    .product(w_product)
  );

  assign busy_out = w_mul_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid        <= 1'b0;
      ctl_memtoreg_out <= 1'b0;
      ctl_regwrite_out <= 1'b0;
      rd_out           <= {RW{1'b0}};
      alu_result_out   <= {XLEN{1'b0}};
      mem_wdata_out    <= {XLEN{1'b0}};
    end else if (nos) begin
      out_valid        <= 1'b0;
      ctl_memtoreg_out <= 1'b0;
      ctl_regwrite_out <= 1'b0;
      rd_out           <= rd_in;
      alu_result_out   <= w_result;
      mem_wdata_out    <= w_fwd_b;
    end else if (w_mul_last) begin
      out_valid        <= 1'b1;
      ctl_memtoreg_out <= ctl_memtoreg_in;
      ctl_regwrite_out <= ctl_regwrite_in;
      rd_out           <= rd_in;
      alu_result_out   <= w_product;
      mem_wdata_out    <= w_fwd_b;
    end else if (w_mul_busy) begin
      out_valid        <= 1'b0;
      ctl_memtoreg_out <= 1'b0;
      ctl_regwrite_out <= 1'b0;
    end else begin
      out_valid        <= in_valid;
      ctl_memtoreg_out <= in_valid & ctl_memtoreg_in;
      ctl_regwrite_out <= in_valid & ctl_regwrite_in;
      rd_out           <= rd_in;
      alu_result_out   <= w_result;
      mem_wdata_out    <= w_fwd_b;
    end
  end

endmodule
